ps2_cursor_tracker: RTL and testbench
=====================================

# ps2_cursor_tracker

Parametrised successor to the single-channel PS/2 mouse packet handler. It consumes completed packets from the PS/2 bit receiver and validates them. It keeps a clamped cursor position and optionally tracks an IntelliMouse wheel. It emits typed draw events (draw, stroke-end, right-click) into an internal first-word-fall-through FIFO read by the framebuffer writer. It sits between the PS/2 receiver and the video-memory write port.

## Interface
Parameters:
- X_W, 10, cursor X width.
- Y_W, 10, cursor Y width.
- COLOR_W, 3, colour field width.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW.
- WHEEL_EN, 0, 1 = expect 4-byte IntelliMouse packets (44 bits), 0 = 3-byte packets (33 bits).
- DW, 2+COLOR_W+X_W+Y_W, record width (derived).

Ports:
- CLK  in  1  single clock, all logic on rising edge.
- RST_N  in  1  synchronous, active-low reset.
- pkt_bits  in  44  raw frame bits from the receiver, one 11-bit frame per byte. Byte k data = [11k+8:11k+1], parity = [11k+9]. Byte 0 = status, 1 = X, 2 = Y, 3 = Z.
- pkt_done  in  1  level from receiver, high while a complete packet is held.
- pkt_nbits  in  6  bits received.
- res_hor  in  X_W  horizontal resolution, e.g. 640.
- res_ver  in  Y_W  vertical resolution, e.g. 480.
- chosen_color  in  COLOR_W  colour stamped into records.
- rd_en  in  1  pop request.
- rd_data  out  DW  head record {kind[1:0], color, x, y}; valid when !fifo_empty.
- fifo_empty  out  1  FIFO empty.
- fifo_full  out  1  FIFO full.
- fifo_count  out  FIFO_AW+1  occupancy.
- cursor_x  out  X_W  current X.
- cursor_y  out  Y_W  current Y.
- wheel_pos  out  8  signed saturating wheel accumulator (0 when WHEEL_EN=0).
- init_mouse  out  1  requests "enable reporting" (F4) from the receiver.
- buttons  out  3  {middle,right,left} from last valid packet.
- bad_pkts  out  8  saturating count of rejected packets.
- lost_events  out  8  saturating count of records dropped (FIFO full or busy).

## Operation
- FSM states: IDLE, APPLY, EMIT.
- IDLE: on rising edge of pkt_done (registered prev-level detector), check validity:
  - pkt_nbits == 33 (WHEEL_EN=0) or 44 (WHEEL_EN=1);
  - every byte has odd parity (parity bit == ~^data);
  - status overflow bits [6],[7] both 0.
- Valid packet: latch fields, go to APPLY. Invalid packet: bad_pkts+1, stay in IDLE.
- APPLY:
  - dx = sign-extend {s[4],X}, dy = {s[5],Y}, as 9-bit two's complement.
  - Compute in X_W+2 signed: nx = clamp(x+dx, 0, res_hor-1), ny = clamp(y−dy, 0, res_ver−1). Y is inverted.
  - Register cursor and buttons.
  - WHEEL_EN: wheel_pos += sign-extend Z[3:0], saturating at −128/+127.
  - Go to EMIT.
- EMIT: form at most one record, priority order:
  1. right-button rising edge → kind 2;
  2. left falling edge → kind 1 (stroke end);
  3. left held and {x,y} != last drawn coordinate → kind 0 (draw); left rising edge always draws.
- On push, update last drawn coordinate. If the FIFO is full and no pop occurs this cycle, drop the record and increment lost_events. Then go to IDLE.
- A pkt_done rising edge while in APPLY/EMIT is not processed; lost_events+1.
- FIFO: registered memory plus FIFO_AW+1-bit read/write pointers. Full/empty use the MSB-differs rule, so all 2**FIFO_AW entries are usable.
  - Pop when rd_en && !fifo_empty; rd_en on empty is ignored.
  - Push and pop in the same cycle are both honoured, including when full.
- Colour is sampled in EMIT.

## Timing
- Reset (RST_N low at a clock edge) sets:
  - cursor_x = res_hor/2 and cursor_y = res_ver/2 (floor, using resolution inputs sampled that cycle);
  - wheel_pos = 0, buttons = 0, counters = 0;
  - FIFO pointers = 0 (fifo_empty = 1, fifo_full = 0, fifo_count = 0);
  - state IDLE, last drawn coordinate = all-ones (never matches a real coordinate);
  - pkt_done edge detector history = 1, so a level already high at release is not taken.
- Reset mid-operation abandons APPLY/EMIT with no push.
- init_mouse is high during reset and for exactly one cycle after RST_N rises, then 0.
- Latency from the cycle pkt_done is first sampled high (cycle n):
  - n+1: cursor, buttons and wheel_pos registered (APPLY);
  - n+2: record written, fifo_empty falls and rd_data is valid (EMIT);
  - n+3: back in IDLE.
- Pop: rd_data advances and fifo_count decrements the cycle after the rd_en edge.
- Counters saturate at 255; they never wrap.

## Test plan
- Reset with res 640×480 → cursor (320,240), fifo_empty = 1, init_mouse high for exactly one cycle after release.
- Valid packet, left = 1, dx = +5, dy = +3 → cursor (325,237) at n+1; record {0,color,325,237} at n+2; an identical follow-up packet (dx = dy = 0) pushes nothing.
- Cursor at (2,478), dx = −10, dy = −10 → clamped to (0,479); dx = +255 from x = 630 → x = 639.
- Bad parity in byte 1, or overflow bit set, or pkt_nbits = 32 → cursor unchanged, no record, bad_pkts increments.
- Fill 16 entries (FIFO_AW = 4) → fifo_full = 1; the next draw is dropped and lost_events = 1; with push and pop in the same full cycle, count stays 16 and order is preserved.
- WHEEL_EN = 1, Z = +7 twenty times → wheel_pos saturates at 127; right press plus left release in one packet → a single kind 2 record.

Source files
------------

// File: rtl/ps2_cursor_tracker_if.sv
// Packet input from the PS/2 bit receiver plus the FWFT read port of the record FIFO.
// The receiver drives pkt_* and the framebuffer writer drives rd_en. A record is popped on
// a clock edge where rd_en is high and fifo_empty is low. rd_en while empty has no effect.
interface ps2_cursor_tracker_if #(
   parameter int X_W     = 10,
   parameter int Y_W     = 10,
   parameter int COLOR_W = 3,
   parameter int FIFO_AW = 4
);
   localparam int DW = 2 + COLOR_W + X_W + Y_W;

   logic [43:0]      pkt_bits;
   logic             pkt_done;
   logic [5:0]       pkt_nbits;
   logic             rd_en;
   logic [DW-1:0]    rd_data;
   logic             fifo_empty;
   logic             fifo_full;
   logic [FIFO_AW:0] fifo_count;

   modport master (
      output pkt_bits, pkt_done, pkt_nbits, rd_en,
      input  rd_data, fifo_empty, fifo_full, fifo_count
   );

   modport slave (
      input  pkt_bits, pkt_done, pkt_nbits, rd_en,
      output rd_data, fifo_empty, fifo_full, fifo_count
   );
endinterface

// File: rtl/ps2_cursor_tracker.sv
// Validates PS/2 mouse packets, tracks a clamped cursor and optional wheel, and queues
// typed draw records (0 draw, 1 stroke end, 2 right click) in a FWFT FIFO.
module ps2_cursor_tracker #(
   parameter int X_W      = 10,
   parameter int Y_W      = 10,
   parameter int COLOR_W  = 3,
   parameter int FIFO_AW  = 4,
   parameter int WHEEL_EN = 0,
   parameter int DW       = 2 + COLOR_W + X_W + Y_W
) (
   input  logic               CLK,
   input  logic               RST_N,
   ps2_cursor_tracker_if.slave bus,
   input  logic [X_W-1:0]     res_hor,
   input  logic [Y_W-1:0]     res_ver,
   input  logic [COLOR_W-1:0] chosen_color,
   output logic [X_W-1:0]     cursor_x,
   output logic [Y_W-1:0]     cursor_y,
   output logic [7:0]         wheel_pos,
   output logic               init_mouse,
   output logic [2:0]         buttons,
   output logic [7:0]         bad_pkts,
   output logic [7:0]         lost_events,
   output logic [1:0]         state_dbg
);
   typedef enum logic [1:0] {IDLE = 2'd0, APPLY = 2'd1, EMIT = 2'd2} state_t;

   localparam int         NBYTES = (WHEEL_EN != 0) ? 4 : 3;
   localparam logic [5:0] NBITS  = (WHEEL_EN != 0) ? 6'd44 : 6'd33;
   localparam int         XS     = X_W + 2;
   localparam int         YS     = Y_W + 2;

   state_t state, state_nxt;
   logic   done_prev, done_rise, pkt_ok;
   logic   take_pkt, reject_pkt, busy_rise, do_apply, do_emit;
   logic   init_q;

   logic [2:0] btn_q, btn_prev;
   logic       sx_q, sy_q;
   logic [7:0] x_q, y_q;
   logic [3:0] z_q;

   logic [X_W+Y_W-1:0] last_xy;
   logic               unused_bits;

   assign done_rise   = bus.pkt_done & ~done_prev;
   assign state_dbg   = state;
   assign init_mouse  = init_q | ~RST_N;
   assign unused_bits = ^{bus.pkt_bits, z_q};

   // A packet is good only with the expected length, odd parity on every byte and no overflow.
   always_comb begin
      pkt_ok = (bus.pkt_nbits == NBITS) && !bus.pkt_bits[7] && !bus.pkt_bits[8];
      for (int k = 0; k < NBYTES; k++)
         if (bus.pkt_bits[11*k+9] != ~^bus.pkt_bits[11*k+1 +: 8]) pkt_ok = 1'b0;
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (done_rise && pkt_ok) state_nxt = APPLY;
         APPLY:   state_nxt = EMIT;
         EMIT:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      take_pkt   = (state == IDLE) && done_rise && pkt_ok;
      reject_pkt = (state == IDLE) && done_rise && !pkt_ok;
      busy_rise  = (state != IDLE) && done_rise;
      do_apply   = (state == APPLY);
      do_emit    = (state == EMIT);
   end

   // Movement arithmetic: signed X_W+2 / Y_W+2 so both underflow and overshoot are visible.
   logic signed [8:0]    dx, dy;
   logic signed [XS-1:0] x_sum, x_max;
   logic signed [YS-1:0] y_sum, y_max;
   logic [X_W-1:0]       nx;
   logic [Y_W-1:0]       ny;
   logic signed [8:0]    w_sum;
   logic [7:0]           w_sat;

   assign dx    = {sx_q, x_q};
   assign dy    = {sy_q, y_q};
   assign x_sum = $signed({2'b00, cursor_x}) + {{(XS-9){dx[8]}}, dx};
   assign y_sum = $signed({2'b00, cursor_y}) - {{(YS-9){dy[8]}}, dy};
   assign x_max = $signed({2'b00, res_hor}) - XS'(1);
   assign y_max = $signed({2'b00, res_ver}) - YS'(1);
   assign w_sum = $signed({wheel_pos[7], wheel_pos}) + $signed({{5{z_q[3]}}, z_q});

   always_comb begin
      if (x_sum[XS-1])       nx = '0;
      else if (x_sum > x_max) nx = x_max[X_W-1:0];
      else                    nx = x_sum[X_W-1:0];
      if (y_sum[YS-1])       ny = '0;
      else if (y_sum > y_max) ny = y_max[Y_W-1:0];
      else                    ny = y_sum[Y_W-1:0];
      case (w_sum[8:7])
         2'b01:   w_sat = 8'h7F;
         2'b10:   w_sat = 8'h80;
         default: w_sat = w_sum[7:0];
      endcase
   end

   // Record selection; right click outranks stroke end, which outranks drawing.
   logic          right_rise, left_fall, left_rise, rec_valid, push, pop, drop;
   logic [1:0]    rec_kind;
   logic [DW-1:0] rec;

   always_comb begin
      right_rise = buttons[1] & ~btn_prev[1];
      left_fall  = ~buttons[0] & btn_prev[0];
      left_rise  = buttons[0] & ~btn_prev[0];
      rec_valid  = right_rise | left_fall |
                   (buttons[0] & (left_rise | ({cursor_x, cursor_y} != last_xy)));
      rec_kind   = right_rise ? 2'd2 : (left_fall ? 2'd1 : 2'd0);
      rec        = {rec_kind, chosen_color, cursor_x, cursor_y};
   end

   logic [DW-1:0]    mem [0:(1<<FIFO_AW)-1];
   logic [FIFO_AW:0] wr_ptr, rd_ptr;

   assign bus.fifo_empty = (wr_ptr == rd_ptr);
   assign bus.fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                           (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
   assign bus.fifo_count = wr_ptr - rd_ptr;
   assign bus.rd_data    = mem[rd_ptr[FIFO_AW-1:0]];
   assign pop            = bus.rd_en & ~bus.fifo_empty;
   assign push           = do_emit & rec_valid & (~bus.fifo_full | pop);
   assign drop           = do_emit & rec_valid & bus.fifo_full & ~pop;

   logic [1:0] lost_inc;
   logic [8:0] lost_sum;
   assign lost_inc = {1'b0, drop} + {1'b0, busy_rise};
   assign lost_sum = {1'b0, lost_events} + {7'd0, lost_inc};

   always_ff @(posedge CLK) begin
      if (push) mem[wr_ptr[FIFO_AW-1:0]] <= rec;
      if (take_pkt) begin
         btn_q <= bus.pkt_bits[3:1];
         sx_q  <= bus.pkt_bits[5];
         sy_q  <= bus.pkt_bits[6];
         x_q   <= bus.pkt_bits[19:12];
         y_q   <= bus.pkt_bits[30:23];
         z_q   <= bus.pkt_bits[37:34];
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         cursor_x    <= res_hor >> 1;
         cursor_y    <= res_ver >> 1;
         wheel_pos   <= '0;
         buttons     <= '0;
         btn_prev    <= '0;
         bad_pkts    <= '0;
         lost_events <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         last_xy     <= '1;
         done_prev   <= 1'b1;
         init_q      <= 1'b1;
      end else begin
         done_prev <= bus.pkt_done;
         init_q    <= 1'b0;
         if (reject_pkt && bad_pkts != 8'hFF) bad_pkts <= bad_pkts + 8'd1;
         lost_events <= lost_sum[8] ? 8'hFF : lost_sum[7:0];
         if (do_apply) begin
            cursor_x <= nx;
            cursor_y <= ny;
            btn_prev <= buttons;
            buttons  <= btn_q;
            if (WHEEL_EN != 0) wheel_pos <= w_sat;
         end
         if (push) begin
            wr_ptr  <= wr_ptr + 1'b1;
            last_xy <= {cursor_x, cursor_y};
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end
endmodule

// File: tb/tb_ps2_cursor_tracker.sv
// Directed bench for ps2_cursor_tracker: a 3-byte instance and a wheel instance share one clock.
module tb_ps2_cursor_tracker;
   localparam int X_W = 10, Y_W = 10, COLOR_W = 3, FIFO_AW = 4;
   localparam int DW  = 2 + COLOR_W + X_W + Y_W;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [X_W-1:0]     res_hor;
   logic [Y_W-1:0]     res_ver;
   logic [COLOR_W-1:0] chosen_color;

   ps2_cursor_tracker_if #(.X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W), .FIFO_AW(FIFO_AW)) bus0 ();
   ps2_cursor_tracker_if #(.X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W), .FIFO_AW(FIFO_AW)) bus1 ();

   logic [X_W-1:0] cx0, cx1;
   logic [Y_W-1:0] cy0, cy1;
   logic [7:0]     wh0, wh1, bad0, bad1, lost0, lost1;
   logic           init0, init1;
   logic [2:0]     btn0, btn1;
   logic [1:0]     st0, st1;

   ps2_cursor_tracker #(.X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W), .FIFO_AW(FIFO_AW), .WHEEL_EN(0)) dut0 (
      .CLK(clk), .RST_N(rst_n), .bus(bus0), .res_hor(res_hor), .res_ver(res_ver),
      .chosen_color(chosen_color), .cursor_x(cx0), .cursor_y(cy0), .wheel_pos(wh0),
      .init_mouse(init0), .buttons(btn0), .bad_pkts(bad0), .lost_events(lost0), .state_dbg(st0));

   ps2_cursor_tracker #(.X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W), .FIFO_AW(FIFO_AW), .WHEEL_EN(1)) dut1 (
      .CLK(clk), .RST_N(rst_n), .bus(bus1), .res_hor(res_hor), .res_ver(res_ver),
      .chosen_color(chosen_color), .cursor_x(cx1), .cursor_y(cy1), .wheel_pos(wh1),
      .init_mouse(init1), .buttons(btn1), .bad_pkts(bad1), .lost_events(lost1), .state_dbg(st1));

   // ---------------- scoreboard ----------------
   int tests = 0;
   int fails = 0;
   logic [DW-1:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] rec(input logic [1:0] k, input logic [2:0] c,
                                         input logic [9:0] x, input logic [9:0] y);
      return {k, c, x, y};
   endfunction

   function automatic logic [10:0] frame(input logic [7:0] d, input bit bad_par);
      logic p;
      p = ~^d;
      if (bad_par) p = ~p;
      return {1'b1, p, d, 1'b0};
   endfunction

   // ---------------- drivers ----------------
   task automatic drive(input bit sel, input logic [7:0] st, input logic [7:0] xb,
                        input logic [7:0] yb, input logic [7:0] zb, input logic [5:0] nb,
                        input bit bad1x);
      logic [43:0] bits;
      bits = {frame(zb, 1'b0), frame(yb, 1'b0), frame(xb, bad1x), frame(st, 1'b0)};
      if (sel) begin
         bus1.pkt_bits = bits; bus1.pkt_nbits = nb; bus1.pkt_done = 1'b1;
      end else begin
         bus0.pkt_bits = bits; bus0.pkt_nbits = nb; bus0.pkt_done = 1'b1;
      end
   endtask

   task automatic release_done();
      bus0.pkt_done = 1'b0;
      bus1.pkt_done = 1'b0;
   endtask

   // Full packet: pkt_done held long enough for APPLY and EMIT, then dropped.
   task automatic send(input bit sel, input logic [7:0] st, input logic [7:0] xb,
                       input logic [7:0] yb, input logic [7:0] zb, input logic [5:0] nb,
                       input bit bad1x);
      @(negedge clk);
      drive(sel, st, xb, yb, zb, nb, bad1x);
      repeat (4) @(negedge clk);
      release_done();
      @(negedge clk);
   endtask

   task automatic drain(input bit sel);
      while (exp_q.size() > 0) begin
         if (sel) begin
            check("pop_nonempty", 32'(bus1.fifo_empty), 32'd0);
            check("pop_data", 32'(bus1.rd_data), 32'(exp_q.pop_front()));
            bus1.rd_en = 1'b1;
         end else begin
            check("pop_nonempty", 32'(bus0.fifo_empty), 32'd0);
            check("pop_data", 32'(bus0.rd_data), 32'(exp_q.pop_front()));
            bus0.rd_en = 1'b1;
         end
         @(negedge clk);
         bus0.rd_en = 1'b0;
         bus1.rd_en = 1'b0;
      end
      check("drained_empty", 32'(sel ? bus1.fifo_empty : bus0.fifo_empty), 32'd1);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [7:0]     st, xb, yb;
      logic [X_W-1:0] ex;
      logic [Y_W-1:0] ey;
      bit             push;
      logic [1:0]     kind;
   } vec_t;

   function automatic vec_t mk(input logic [7:0] st, input logic [7:0] xb, input logic [7:0] yb,
                               input int ex, input int ey, input bit push, input int kind);
      vec_t v;
      v.st = st; v.xb = xb; v.yb = yb;
      v.ex = X_W'(ex); v.ey = Y_W'(ey);
      v.push = push; v.kind = 2'(kind);
      return v;
   endfunction

   vec_t vecs[15];

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = mk(8'h09, 8'h05, 8'h03, 325, 237, 1, 0);
      vecs[1]  = mk(8'h09, 8'h00, 8'h00, 325, 237, 0, 0);
      vecs[2]  = mk(8'h08, 8'h00, 8'h00, 325, 237, 1, 1);
      vecs[3]  = mk(8'h08, 8'hFF, 8'h00, 580, 237, 0, 0);
      vecs[4]  = mk(8'h08, 8'hFF, 8'h00, 639, 237, 0, 0);
      vecs[5]  = mk(8'h19, 8'hF6, 8'h00, 629, 237, 1, 0);
      vecs[6]  = mk(8'h29, 8'h00, 8'h00, 629, 479, 1, 0);
      vecs[7]  = mk(8'h0B, 8'h00, 8'h00, 629, 479, 1, 2);
      vecs[8]  = mk(8'h09, 8'h01, 8'h00, 630, 479, 1, 0);
      vecs[9]  = mk(8'h0A, 8'h00, 8'h00, 630, 479, 1, 2);
      vecs[10] = mk(8'h08, 8'hFF, 8'h00, 639, 479, 0, 0);
      vecs[11] = mk(8'h18, 8'h00, 8'h01, 383, 478, 0, 0);
      vecs[12] = mk(8'h18, 8'h00, 8'h00, 127, 478, 0, 0);
      vecs[13] = mk(8'h18, 8'h83, 8'h00, 2, 478, 0, 0);
      vecs[14] = mk(8'h38, 8'hF6, 8'hF6, 0, 479, 0, 0);

      res_hor = 10'd640; res_ver = 10'd480; chosen_color = 3'd0;
      bus0.rd_en = 1'b0; bus1.rd_en = 1'b0;
      bus1.pkt_done = 1'b0; bus1.pkt_bits = '0; bus1.pkt_nbits = '0;

      // Reset with a valid packet level already high: it must not be taken at release.
      rst_n = 1'b0;
      drive(1'b0, 8'h09, 8'h05, 8'h00, 8'h00, 6'd33, 1'b0);
      repeat (3) @(negedge clk);
      check("init_in_reset", 32'(init0), 32'd1);
      rst_n = 1'b1;
      check("init_after_release", 32'(init0), 32'd1);
      @(negedge clk);
      check("init_dropped", 32'(init0), 32'd0);
      check("rst_cursor_x", 32'(cx0), 32'd320);
      check("rst_cursor_y", 32'(cy0), 32'd240);
      check("rst_empty", 32'(bus0.fifo_empty), 32'd1);
      check("rst_full", 32'(bus0.fifo_full), 32'd0);
      check("rst_count", 32'(bus0.fifo_count), 32'd0);
      check("rst_counters", 32'({bad0, lost0, wh0}), 32'd0);
      check("rst_state", 32'(st0), 32'd0);
      repeat (3) @(negedge clk);
      check("held_level_ignored_x", 32'(cx0), 32'd320);
      check("held_level_ignored_fifo", 32'(bus0.fifo_empty), 32'd1);
      release_done();
      @(negedge clk);

      // Table-driven movement, clamping and record typing.
      for (int i = 0; i < 15; i++) begin
         chosen_color = 3'(i);
         send(1'b0, vecs[i].st, vecs[i].xb, vecs[i].yb, 8'h00, 6'd33, 1'b0);
         if (vecs[i].push)
            exp_q.push_back(rec(vecs[i].kind, 3'(i), vecs[i].ex, vecs[i].ey));
         check($sformatf("vec%0d_x", i), 32'(cx0), 32'(vecs[i].ex));
         check($sformatf("vec%0d_y", i), 32'(cy0), 32'(vecs[i].ey));
         check($sformatf("vec%0d_btn", i), 32'(btn0), 32'(vecs[i].st[2:0]));
         check($sformatf("vec%0d_count", i), 32'(bus0.fifo_count), 32'(exp_q.size()));
      end
      drain(1'b0);

      // Rejected packets: bad parity in byte 1, overflow bit, short length.
      send(1'b0, 8'h09, 8'h05, 8'h00, 8'h00, 6'd33, 1'b1);
      check("bad_parity_cnt", 32'(bad0), 32'd1);
      send(1'b0, 8'h49, 8'h05, 8'h00, 8'h00, 6'd33, 1'b0);
      check("bad_ovf_cnt", 32'(bad0), 32'd2);
      send(1'b0, 8'h09, 8'h05, 8'h00, 8'h00, 6'd32, 1'b0);
      check("bad_len_cnt", 32'(bad0), 32'd3);
      check("bad_cursor", 32'({cx0, cy0}), 32'({10'd0, 10'd479}));
      check("bad_no_record", 32'(bus0.fifo_empty), 32'd1);

      // Latency: APPLY at n+1, record visible at n+2, IDLE again after.
      chosen_color = 3'd5;
      @(negedge clk);
      drive(1'b0, 8'h09, 8'h03, 8'h00, 8'h00, 6'd33, 1'b0);
      @(negedge clk);
      check("lat_n_state", 32'(st0), 32'd1);
      check("lat_n_x", 32'(cx0), 32'd0);
      @(negedge clk);
      check("lat_n1_x", 32'(cx0), 32'd3);
      check("lat_n1_empty", 32'(bus0.fifo_empty), 32'd1);
      @(negedge clk);
      check("lat_n2_empty", 32'(bus0.fifo_empty), 32'd0);
      check("lat_n2_data", 32'(bus0.rd_data), 32'(rec(2'd0, 3'd5, 10'd3, 10'd479)));
      check("lat_n2_state", 32'(st0), 32'd0);
      release_done();
      @(negedge clk);
      exp_q.push_back(rec(2'd0, 3'd5, 10'd3, 10'd479));
      drain(1'b0);

      // Fill the FIFO, then overflow by one.
      chosen_color = 3'd1;
      for (int i = 0; i < 16; i++) begin
         send(1'b0, 8'h09, 8'h01, 8'h00, 8'h00, 6'd33, 1'b0);
         exp_q.push_back(rec(2'd0, 3'd1, 10'(4 + i), 10'd479));
      end
      check("fill_full", 32'(bus0.fifo_full), 32'd1);
      check("fill_count", 32'(bus0.fifo_count), 32'd16);
      send(1'b0, 8'h09, 8'h01, 8'h00, 8'h00, 6'd33, 1'b0);
      check("drop_lost", 32'(lost0), 32'd1);
      check("drop_count", 32'(bus0.fifo_count), 32'd16);
      check("drop_x", 32'(cx0), 32'd20);

      // Push and pop in the same cycle while full.
      @(negedge clk);
      drive(1'b0, 8'h09, 8'h01, 8'h00, 8'h00, 6'd33, 1'b0);
      @(negedge clk);
      @(negedge clk);
      check("pp_head", 32'(bus0.rd_data), 32'(exp_q[0]));
      bus0.rd_en = 1'b1;
      @(negedge clk);
      bus0.rd_en = 1'b0;
      void'(exp_q.pop_front());
      exp_q.push_back(rec(2'd0, 3'd1, 10'd21, 10'd479));
      check("pp_count", 32'(bus0.fifo_count), 32'd16);
      check("pp_full", 32'(bus0.fifo_full), 32'd1);
      check("pp_lost", 32'(lost0), 32'd1);
      release_done();
      @(negedge clk);
      drain(1'b0);

      bus0.rd_en = 1'b1;
      @(negedge clk);
      bus0.rd_en = 1'b0;
      check("empty_pop_count", 32'(bus0.fifo_count), 32'd0);
      check("empty_pop_empty", 32'(bus0.fifo_empty), 32'd1);

      // pkt_done rising while busy is counted as lost, not processed.
      @(negedge clk);
      drive(1'b0, 8'h09, 8'h00, 8'h00, 8'h00, 6'd33, 1'b0);
      @(negedge clk);
      release_done();
      @(negedge clk);
      bus0.pkt_done = 1'b1;
      @(negedge clk);
      release_done();
      @(negedge clk);
      check("busy_lost", 32'(lost0), 32'd2);
      check("busy_bad", 32'(bad0), 32'd3);
      check("busy_state", 32'(st0), 32'd0);
      check("busy_empty", 32'(bus0.fifo_empty), 32'd1);

      // Wheel instance: saturation, negative step, length check, right-click priority.
      chosen_color = 3'd6;
      for (int i = 0; i < 20; i++) begin
         send(1'b1, 8'h08, 8'h00, 8'h00, 8'h07, 6'd44, 1'b0);
         if (i == 4) check("wheel_35", 32'(wh1), 32'd35);
      end
      check("wheel_sat", 32'(wh1), 32'd127);
      send(1'b1, 8'h08, 8'h00, 8'h00, 8'hF8, 6'd44, 1'b0);
      check("wheel_neg", 32'(wh1), 32'd119);
      send(1'b1, 8'h08, 8'h00, 8'h00, 8'h01, 6'd33, 1'b0);
      check("wheel_len_bad", 32'(bad1), 32'd1);
      check("wheel_len_unchanged", 32'(wh1), 32'd119);
      send(1'b1, 8'h09, 8'h00, 8'h00, 8'h00, 6'd44, 1'b0);
      exp_q.push_back(rec(2'd0, 3'd6, 10'd320, 10'd240));
      send(1'b1, 8'h0A, 8'h00, 8'h00, 8'h00, 6'd44, 1'b0);
      exp_q.push_back(rec(2'd2, 3'd6, 10'd320, 10'd240));
      check("wheel_rec_count", 32'(bus1.fifo_count), 32'd2);
      drain(1'b1);
      check("nowheel_zero", 32'(wh0), 32'd0);

      // Reset during EMIT abandons the pending record.
      @(negedge clk);
      drive(1'b0, 8'h09, 8'h01, 8'h00, 8'h00, 6'd33, 1'b0);
      @(negedge clk);
      @(negedge clk);
      check("midrst_applied_x", 32'(cx0), 32'd22);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_empty", 32'(bus0.fifo_empty), 32'd1);
      check("midrst_cursor", 32'({cx0, cy0}), 32'({10'd320, 10'd240}));
      check("midrst_state", 32'(st0), 32'd0);
      check("midrst_counters", 32'({bad0, lost0}), 32'd0);
      release_done();
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("midrst_still_empty", 32'(bus0.fifo_empty), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
